// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide, fixed-latency memory port between
// the I-cache fill path and the D-cache fill/writeback path.
// Optional feature macro: ROUND_ROBIN_EN (round-robin arbitration instead of
// fixed D-over-I priority).
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_req,
    input  logic [WORD_SIZE-1:0]   i_addr,
    output logic [4*WORD_SIZE-1:0] i_line,
    output logic                   i_ready,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [WORD_SIZE-1:0]   d_addr,
    input  logic [4*WORD_SIZE-1:0] d_wline,
    output logic [4*WORD_SIZE-1:0] d_rline,
    output logic                   d_ready,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [WORD_SIZE-1:0]   mem_addr,
    output logic [4*WORD_SIZE-1:0] mem_wline,
    input  logic [4*WORD_SIZE-1:0] mem_rline
);

    localparam int unsigned LINE_BITS = 4 * WORD_SIZE;
    localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state,     w_state;
    logic [CNT_W-1:0]     r_cnt,       w_cnt;
    logic                 r_win_d,     w_win_d;
    logic                 r_mem_read,  w_mem_read;
    logic                 r_mem_write, w_mem_write;
    logic [WORD_SIZE-1:0] r_mem_addr,  w_mem_addr;
    logic [LINE_BITS-1:0] r_mem_wline, w_mem_wline;
    logic [LINE_BITS-1:0] r_i_line,    w_i_line;
    logic [LINE_BITS-1:0] r_d_rline,   w_d_rline;
    logic                 r_i_ready,   w_i_ready;
    logic                 r_d_ready,   w_d_ready;
    logic                 w_pick_d;
    logic                 w_d_write;

`ifdef ROUND_ROBIN_EN
    // r_prio_d = 1 means D wins the next contested grant
    logic r_prio_d, w_prio_d;

    // Round-robin winner selection
    always_comb begin
        w_pick_d = d_req && (!i_req || r_prio_d);
    end
`else
    // Fixed priority: D over I so a load/store never waits behind a fetch
    always_comb begin
        w_pick_d = d_req;
    end
`endif

    assign w_d_write = w_pick_d && d_we;

    // Next-state and registered-output logic
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_win_d     = r_win_d;
        w_mem_read  = r_mem_read;
        w_mem_write = r_mem_write;
        w_mem_addr  = r_mem_addr;
        w_mem_wline = r_mem_wline;
        w_i_line    = r_i_line;
        w_d_rline   = r_d_rline;
        w_i_ready   = 1'b0;
        w_d_ready   = 1'b0;
`ifdef ROUND_ROBIN_EN
        w_prio_d    = r_prio_d;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_state     = S_BUSY;
                    w_win_d     = w_pick_d;
                    w_mem_read  = !w_d_write;
                    w_mem_write = w_d_write;
                    w_mem_addr  = (w_pick_d ? d_addr : i_addr) & ~WORD_SIZE'(3);
                    w_mem_wline = w_pick_d ? d_wline : '0;
                    w_cnt       = CNT_W'(LATENCY - 1);
`ifdef ROUND_ROBIN_EN
                    w_prio_d    = !w_pick_d;
`endif
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state     = S_RESP;
                    w_mem_read  = 1'b0;
                    w_mem_write = 1'b0;
                    w_mem_addr  = '0;
                    w_mem_wline = '0;
                    if (r_mem_read) begin
                        if (r_win_d) w_d_rline = mem_rline;
                        else         w_i_line  = mem_rline;
                    end
                    w_d_ready = r_win_d;
                    w_i_ready = !r_win_d;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state     = S_IDLE;
                w_mem_read  = 1'b0;
                w_mem_write = 1'b0;
                w_mem_addr  = '0;
                w_mem_wline = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_win_d     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wline <= '0;
            r_i_line    <= '0;
            r_d_rline   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            r_prio_d    <= 1'b1;
`endif
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_win_d     <= w_win_d;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_mem_addr  <= w_mem_addr;
            r_mem_wline <= w_mem_wline;
            r_i_line    <= w_i_line;
            r_d_rline   <= w_d_rline;
            r_i_ready   <= w_i_ready;
            r_d_ready   <= w_d_ready;
`ifdef ROUND_ROBIN_EN
            r_prio_d    <= w_prio_d;
`endif
        end
    end

    assign i_line    = r_i_line;
    assign i_ready   = r_i_ready;
    assign d_rline   = r_d_rline;
    assign d_ready   = r_d_ready;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wline = r_mem_wline;

endmodule
